// File: rtl/da_shift_acc_if.sv
// Bus bundle for the distributed-arithmetic shift-accumulate block.
// master drives start, table entries A1..A4 and coefficient words w0/w1.
// slave returns busy, the one-cycle valid pulse and the held result y.
interface da_shift_acc_if #(
    parameter int WB = 8,
    parameter int DW = 10
);
    logic                      start;
    logic signed [DW-1:0]      A1;
    logic signed [DW-1:0]      A2;
    logic signed [DW-1:0]      A3;
    logic signed [DW-1:0]      A4;
    logic signed [WB-1:0]      w0;
    logic signed [WB-1:0]      w1;
    logic                      busy;
    logic                      valid;
    logic signed [DW+WB-1:0]   y;

    modport master (
        output start, A1, A2, A3, A4, w0, w1,
        input  busy, valid, y
    );

    modport slave (
        input  start, A1, A2, A3, A4, w0, w1,
        output busy, valid, y
    );
endinterface

// File: rtl/da_shift_acc.sv
// Purpose: bit-serial distributed-arithmetic product-sum of two signed coefficient words.
// Latency: start accepted at edge E0 -> y/valid after edge E(WB); back-to-back every WB+1 cycles.
// Backpressure: none; start is ignored while busy (no queuing), y is held until the next completion.
// Ports: clk (rising-edge clock), r (async active-high reset), bus (slave modport:
//        start/A1..A4/w0/w1 in, busy/valid/y out).
module da_shift_acc #(
    parameter int WB = 8,
    parameter int DW = 10
) (
    input  logic            clk,
    input  logic            r,
    da_shift_acc_if.slave   bus
);
    localparam int AW = DW + WB;
    localparam int KW = (WB > 1) ? $clog2(WB) : 1;
    localparam logic [KW-1:0] K_TOP = KW'(WB - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                 state;
    state_t                 state_nxt;

    logic signed [DW-1:0]   a1_q;
    logic signed [DW-1:0]   a2_q;
    logic signed [DW-1:0]   a3_q;
    logic signed [DW-1:0]   a4_q;
    logic [WB-1:0]          w0_q;
    logic [WB-1:0]          w1_q;
    logic signed [AW-1:0]   acc;
    logic signed [AW-1:0]   acc_nxt;
    logic signed [AW-1:0]   acc_sh;
    logic signed [AW-1:0]   y_q;
    logic [KW-1:0]          k;
    logic                   valid_q;

    logic [1:0]             addr;
    logic signed [DW-1:0]   t_sel;
    logic signed [AW-1:0]   t_ext;
    logic                   load;
    logic                   step;
    logic                   last;

    // Control: IDLE accepts start (also in the cycle valid is high), RUN walks k down to 0.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        step      = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    load      = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (k == '0) begin
                    last      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath: bit k of each coefficient forms the table address; the MSB
    // carries negative weight in two's complement, hence the subtract.
    always_comb begin
        addr = {w1_q[k], w0_q[k]};
        case (addr)
            2'b00:   t_sel = a1_q;
            2'b01:   t_sel = a2_q;
            2'b10:   t_sel = a3_q;
            default: t_sel = a4_q;
        endcase
        t_ext  = {{WB{t_sel[DW-1]}}, t_sel};
        acc_sh = acc <<< 1;
        if (k == K_TOP) begin
            acc_nxt = acc_sh - t_ext;
        end else begin
            acc_nxt = acc_sh + t_ext;
        end
    end

    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            a1_q    <= '0;
            a2_q    <= '0;
            a3_q    <= '0;
            a4_q    <= '0;
            w0_q    <= '0;
            w1_q    <= '0;
            acc     <= '0;
            k       <= '0;
            y_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (load) begin
                a1_q <= bus.A1;
                a2_q <= bus.A2;
                a3_q <= bus.A3;
                a4_q <= bus.A4;
                w0_q <= bus.w0;
                w1_q <= bus.w1;
                acc  <= '0;
                k    <= K_TOP;
            end
            if (step) begin
                acc <= acc_nxt;
                // k parks at 0 after the final bit instead of wrapping.
                k   <= last ? k : k - 1'b1;
                if (last) begin
                    y_q     <= acc_nxt;
                    valid_q <= 1'b1;
                end
            end
        end
    end

    assign bus.busy  = (state == RUN);
    assign bus.valid = valid_q;
    assign bus.y     = y_q;
endmodule

// File: tb/tb_da_shift_acc.sv
// Testbench for da_shift_acc: table of directed vectors, handshake and reset
// corner sequences, and randomized operands checked against an arithmetic
// product-sum model.
module tb_da_shift_acc;
    localparam int WB = 8;
    localparam int DW = 10;

    logic clk;
    logic r;

    da_shift_acc_if #(.WB(WB), .DW(DW)) bus ();

    da_shift_acc #(.WB(WB), .DW(DW)) dut (
        .clk (clk),
        .r   (r),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        int          a1;
        int          a2;
        int          a3;
        int          a4;
        logic [7:0]  w0;
        logic [7:0]  w1;
        int          exp_y;
    } vec_t;

    typedef int arr4_t [4];

    task automatic chk(input string nm, input longint act, input longint exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: y = sum_k weight(k) * T(k), weight = -2^k for the sign bit, +2^k otherwise.
    function automatic longint model(input arr4_t a, input logic [7:0] w0, input logic [7:0] w1);
        longint s;
        longint term;
        int     idx;
        s = 0;
        for (int b = 0; b < WB; b++) begin
            idx  = {30'd0, w1[b], w0[b]};
            term = longint'(a[idx]) * (longint'(1) << b);
            s    = (b == WB - 1) ? s - term : s + term;
        end
        return s;
    endfunction

    task automatic set_ops(input int a1, input int a2, input int a3, input int a4,
                           input logic [7:0] w0, input logic [7:0] w1);
        bus.A1 = DW'(a1);
        bus.A2 = DW'(a2);
        bus.A3 = DW'(a3);
        bus.A4 = DW'(a4);
        bus.w0 = w0;
        bus.w1 = w1;
    endtask

    // Pulses start for one edge, then waits (bounded) for valid.
    task automatic run_one(input int a1, input int a2, input int a3, input int a4,
                           input logic [7:0] w0, input logic [7:0] w1,
                           output longint yo, output int lat, output int busy_cnt);
        set_ops(a1, a2, a3, a4, w0, w1);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        yo       = 0;
        lat      = 99;
        busy_cnt = bus.busy ? 1 : 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (bus.valid) begin
                lat = i;
                yo  = longint'(bus.y);
                break;
            end
            if (bus.busy) busy_cnt++;
        end
    endtask

    vec_t   tbl [8];
    longint yo;
    int     lat;
    int     bc;
    int     nv;
    int     vpos [3];
    int     nbusy;
    arr4_t  ar;
    logic [7:0] rw0;
    logic [7:0] rw1;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0] = '{0,    1,   0,    0,    8'h05, 8'h00, 5};
        tbl[1] = '{3,    0,   0,    0,    8'h00, 8'h00, -3};
        tbl[2] = '{0,    0,   0,    -512, 8'h80, 8'h80, 65536};
        tbl[3] = '{0,    0,   0,    511,  8'h80, 8'h80, -65408};
        tbl[4] = '{0,    1,   0,    0,    8'h80, 8'h00, -128};
        tbl[5] = '{0,    0,   0,    0,    8'hFF, 8'hFF, 0};
        tbl[6] = '{0,    0,   -1,   0,    8'h00, 8'hFF, 1};
        tbl[7] = '{511,  511, 511,  511,  8'h3C, 8'hA5, -511};

        // Reset state, checked while r is still asserted.
        r = 1'b1;
        bus.start = 1'b0;
        set_ops(0, 0, 0, 0, 8'h00, 8'h00);
        #12;
        chk("reset_busy",  bus.busy,  0);
        chk("reset_valid", bus.valid, 0);
        chk("reset_y",     bus.y,     0);
        tick();
        r = 1'b0;
        tick();

        // Directed vectors.
        for (int i = 0; i < 8; i++) begin
            run_one(tbl[i].a1, tbl[i].a2, tbl[i].a3, tbl[i].a4, tbl[i].w0, tbl[i].w1, yo, lat, bc);
            chk($sformatf("vec%0d_y", i), yo, tbl[i].exp_y);
            chk($sformatf("vec%0d_latency", i), lat, WB);
            chk($sformatf("vec%0d_busy_cycles", i), bc, WB);
            tick();
            chk($sformatf("vec%0d_valid_width", i), bus.valid, 0);
        end

        // start held high: results every WB+1 cycles.
        set_ops(0, 1, 0, 0, 8'h05, 8'h00);
        bus.start = 1'b1;
        tick();
        nv = 0;
        for (int i = 1; i <= 27; i++) begin
            tick();
            if (bus.valid) begin
                if (nv < 3) vpos[nv] = i;
                nv++;
                chk("held_start_y", bus.y, 5);
            end
        end
        bus.start = 1'b0;
        chk("held_start_count", nv, 3);
        chk("held_start_pos0", vpos[0], 8);
        chk("held_start_pos1", vpos[1], 17);
        chk("held_start_pos2", vpos[2], 26);
        for (int i = 0; i < 12; i++) begin
            tick();
            if (!bus.busy && !bus.valid) break;
        end

        // start pulses and operand changes during RUN are ignored.
        set_ops(0, 1, 0, 0, 8'h05, 8'h00);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        set_ops(100, -200, 300, -400, 8'hAA, 8'h55);
        nv = 0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (bus.valid) begin
                nv++;
                chk("ignore_valid_edge", c, 8);
                chk("ignore_y", bus.y, 5);
            end
            bus.start = (c <= 6);
        end
        bus.start = 1'b0;
        chk("ignore_valid_count", nv, 1);
        nv = 0;
        nbusy = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (bus.valid) nv++;
            if (bus.busy) nbusy++;
        end
        chk("no_queue_valid", nv, 0);
        chk("no_queue_busy", nbusy, 0);

        // Reset in the middle of a computation.
        set_ops(0, 0, 0, 511, 8'h80, 8'h80);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        tick();
        r = 1'b1;
        #1;
        chk("midrst_busy",  bus.busy,  0);
        chk("midrst_valid", bus.valid, 0);
        chk("midrst_y",     bus.y,     0);
        tick();
        tick();
        r = 1'b0;
        nv = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (bus.valid) nv++;
        end
        chk("midrst_no_valid", nv, 0);
        chk("midrst_y_held", bus.y, 0);
        run_one(0, 1, 0, 0, 8'h05, 8'h00, yo, lat, bc);
        chk("post_rst_y", yo, 5);
        chk("post_rst_latency", lat, WB);

        // Randomized operands, back-to-back, against the arithmetic model.
        for (int n = 0; n < 1000; n++) begin
            for (int j = 0; j < 4; j++) begin
                case ($urandom_range(0, 7))
                    0:       ar[j] = -512;
                    1:       ar[j] = 511;
                    default: ar[j] = int'($urandom_range(0, 1023)) - 512;
                endcase
            end
            rw0 = 8'($urandom_range(0, 255));
            rw1 = 8'($urandom_range(0, 255));
            run_one(ar[0], ar[1], ar[2], ar[3], rw0, rw1, yo, lat, bc);
            chk($sformatf("rand%0d_y", n), yo, model(ar, rw0, rw1));
            if (lat != WB) chk($sformatf("rand%0d_latency", n), lat, WB);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/da_shift_acc.md
DA_SHIFT_ACC -- requirements
Module: da_shift_acc

Interface
REQ-001 Parameter: WB, 8, coefficient word width in bits (bit-serial cycle count).
REQ-002 Parameter: DW, 10, signed table-entry width.
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: r  input  1  reset, asynchronous, active-high.
REQ-005 Port: start  input  1  request to begin one product-sum; sampled only in IDLE.
REQ-006 Port: A1, A2, A3, A4  input  DW each  signed two's-complement table entries from the input-table stage.
REQ-007 Port: w0, w1  input  WB each  signed two's-complement coefficient words.
REQ-008 Port: busy  output  1  high while a computation is in progress.
REQ-009 Port: valid  output  1  one-cycle pulse marking a new y.
REQ-010 Port: y  output  DW+WB  signed result, held until the next completion.

Function
REQ-011 FSM SHALL have two states: IDLE and RUN.
REQ-012 IDLE with start=1 at an edge SHALL latch A1..A4, w0 and w1, clear the accumulator, load bit index k=WB-1, set busy=1, and enter RUN.
REQ-013 Input changes after the latching edge SHALL NOT affect the running computation.
REQ-014 Each RUN edge SHALL select entry T by address {w1[k],w0[k]}: 00->A1, 01->A2, 10->A3, 11->A4.
REQ-015 Each RUN edge SHALL update acc = 2*acc - T when k=WB-1, else acc = 2*acc + T, with T sign-extended to DW+WB bits, then decrement k.
REQ-016 Result SHALL equal the exact sum over k of (k=WB-1 ? -2^k : 2^k)*T(k), with no overflow or rounding in DW+WB bits.
REQ-017 At the RUN edge processing k=0, the block SHALL load y with the final acc, set valid=1 and busy=0, and return to IDLE.
REQ-018 Latency: start sampled at edge E0 SHALL give y and valid visible after edge E(WB), i.e. edge E8 for WB=8.
REQ-019 valid SHALL be high for exactly one cycle per completion, and SHALL be low at every other time.
REQ-020 start during RUN SHALL be ignored, with no queuing.
REQ-021 start=1 in the cycle valid is high (state IDLE) SHALL be accepted, giving back-to-back results every WB+1 cycles.
REQ-022 y SHALL hold its last value while IDLE and during RUN.
REQ-023 Zero-valued table entries or coefficients SHALL need no special case; the arithmetic SHALL be uniform.

Reset
REQ-024 While r=1, state=IDLE and busy=0, valid=0, y=0, acc=0, k=0, and the latched operand registers are 0, regardless of clk.
REQ-025 Reset asserted mid-RUN SHALL abort the computation with no valid pulse and no y update.
REQ-026 After r deasserts, the first start SHALL behave per REQ-012.

Verification
REQ-027 Basic: A1=0, A2=1, A3=A4=0, w0=8'h05, w1=8'h00, start pulse -> valid after 8 edges, y=5, busy high for exactly 8 cycles.
REQ-028 Sign bit: A1=3, A2=A3=A4=0, w0=w1=8'h00 -> y=-3; then A4=-512, A1=0, w0=w1=8'h80 -> y=65536 (18'h10000).
REQ-029 Extremes: A4=511, others 0, w0=w1=8'h80 -> y=-65408; A2=1, w0=8'h80, w1=0 -> y=-128.
REQ-030 Handshake: start held high continuously -> valid every 9 cycles; start pulses at RUN cycles 2-7 ignored; operand changes mid-RUN do not alter y.
REQ-031 Reset mid-operation: r pulsed at RUN cycle 4 -> busy=0, valid stays 0, y=0; a following start with A2=1, w0=8'h05, w1=0 gives y=5.
REQ-032 Random: 1000 random A1..A4/w0/w1 sets checked against the REQ-016 reference-model sum, including entries -512 and 511.
